// File: rtl/panda_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; resolved branches train the table and the hit/miss statistics.
module panda_branch_predictor #(
  parameter int Width   = 32,
  parameter int Entries = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] lookup_pc_i,
  output logic             pred_taken_o,
  output logic [Width-1:0] pred_target_o,
  input  logic             update_valid_i,
  input  logic [Width-1:0] update_pc_i,
  input  logic             update_jump_i,
  input  logic             update_taken_i,
  input  logic [Width-1:0] update_target_i,
  input  logic             update_pred_taken_i,
  input  logic [Width-1:0] update_pred_target_i,
  output logic             mispredict_o,
  output logic [31:0]      hit_count_o,
  output logic [31:0]      miss_count_o
);

  localparam int IdxBits = $clog2(Entries);
  localparam int TagBits = Width - IdxBits - 2;

  // Only valid bits are reset; payload storage is qualified by valid
  logic [Entries-1:0] valid_reg;
  logic [TagBits-1:0] tag_reg    [Entries];
  logic [Width-2:0]   target_reg [Entries];
  logic [1:0]         cnt_reg    [Entries];
  logic               jump_reg   [Entries];

  logic [31:0] hit_count_reg;
  logic [31:0] miss_count_reg;

  logic [IdxBits-1:0] lookup_idx;
  logic [TagBits-1:0] lookup_tag;
  logic               lookup_hit;
  logic [Width-1:0]   seq_pc;

  logic [IdxBits-1:0] upd_idx;
  logic [TagBits-1:0] upd_tag;
  logic               upd_hit;
  logic [1:0]         upd_cnt;
  logic [1:0]         cnt_next;
  logic               target_diff;
  logic               mispredict;
  logic               table_we;

  logic unused_bits;
  assign unused_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0],
                         update_target_i[0], update_pred_target_i[0]};

  // Lookup path
  assign lookup_idx = lookup_pc_i[IdxBits+1:2];
  assign lookup_tag = lookup_pc_i[Width-1:IdxBits+2];
  assign lookup_hit = valid_reg[lookup_idx] && (tag_reg[lookup_idx] == lookup_tag);
  assign seq_pc     = lookup_pc_i + Width'(4);

  assign pred_taken_o  = lookup_hit && (jump_reg[lookup_idx] || cnt_reg[lookup_idx][1]);
  assign pred_target_o = lookup_hit ? {target_reg[lookup_idx], 1'b0}
                                    : {seq_pc[Width-1:1], 1'b0};

  // Resolution path
  assign upd_idx = update_pc_i[IdxBits+1:2];
  assign upd_tag = update_pc_i[Width-1:IdxBits+2];
  assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
  assign upd_cnt = cnt_reg[upd_idx];

  assign target_diff = update_target_i[Width-1:1] != update_pred_target_i[Width-1:1];
  assign mispredict  = update_valid_i &&
                       ((update_taken_i != update_pred_taken_i) ||
                        (update_taken_i && target_diff));
  assign mispredict_o = mispredict;

  always_comb begin
    cnt_next = upd_cnt;
    if (update_taken_i) begin
      if (upd_cnt != 2'b11) cnt_next = upd_cnt + 2'd1;
    end else begin
      if (upd_cnt != 2'b00) cnt_next = upd_cnt - 2'd1;
    end
  end

  // A not-taken miss leaves the table untouched
  assign table_we = !rst_i && update_valid_i && (upd_hit || update_taken_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg      <= '0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if (update_valid_i) begin
      if (mispredict) miss_count_reg <= miss_count_reg + 32'd1;
      else            hit_count_reg  <= hit_count_reg + 32'd1;
      if (!upd_hit && update_taken_i) valid_reg[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (table_we) begin
      if (upd_hit) begin
        cnt_reg[upd_idx] <= cnt_next;
        if (update_taken_i) begin
          target_reg[upd_idx] <= update_target_i[Width-1:1];
          jump_reg[upd_idx]   <= update_jump_i;
        end
      end else begin
        tag_reg[upd_idx]    <= upd_tag;
        target_reg[upd_idx] <= update_target_i[Width-1:1];
        cnt_reg[upd_idx]    <= update_jump_i ? 2'b11 : 2'b10;
        jump_reg[upd_idx]   <= update_jump_i;
      end
    end
  end

  assign hit_count_o  = hit_count_reg;
  assign miss_count_o = miss_count_reg;

endmodule
